// File: rtl/ifmap_streamer.sv
// Streams a raster feature map from SRAM into a 3x3 line-buffer pipeline and flags complete windows.
// Define IFMAP_STREAMER_PAD_EN to add a one-pixel zero border around the map.
module ifmap_streamer #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_img_w,
  input  logic [DIM_W-1:0]  i_img_h,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_mem_ren,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [15:0]       i_mem_rdata,
  output logic [15:0]       o_stream_data,
  output logic              o_stream_valid,
  output logic              o_win_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = DIM_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_next_state;

  logic [CW-1:0]     r_row, r_col, r_sl_m1, r_sh_m1;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_iss_v, r_iss_win, r_p1_v, r_p1_mem, r_p1_win, r_p2_win;
  logic              r_mem_ren, r_stream_valid, r_win_valid, r_busy, r_done;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_stream_data;

  logic              w_accept, w_legal, w_last, w_issue, w_pos_mem, w_pos_win;
  logic [CW-1:0]     w_sl_m1_in, w_sh_m1_in, w_row, w_col;
  logic [ADDR_W-1:0] w_src;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_row == r_sh_m1) && (r_col == r_sl_m1);

`ifdef IFMAP_STREAMER_PAD_EN
  assign w_legal    = (i_img_w != '0) && (i_img_h != '0);
  assign w_sl_m1_in = {1'b0, i_img_w} + CW'(1);
  assign w_sh_m1_in = {1'b0, i_img_h} + CW'(1);
  // Border ring is synthesised as zeros; only interior positions touch memory.
  assign w_pos_mem  = (w_row != '0) && (w_col != '0) && (w_row != r_sh_m1) && (w_col != r_sl_m1);
`else
  assign w_legal    = (i_img_w >= DIM_W'(3)) && (i_img_h >= DIM_W'(3));
  assign w_sl_m1_in = {1'b0, i_img_w} - CW'(1);
  assign w_sh_m1_in = {1'b0, i_img_h} - CW'(1);
  assign w_pos_mem  = 1'b1;
`endif

  assign w_pos_win = (w_row >= CW'(2)) && (w_col >= CW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = w_legal ? S_STREAM : S_DONE;
      S_STREAM: if (w_last) w_next_state = S_DRAIN;
      // Stream register stage still holds the last pixel; it retires while DONE is entered.
      S_DRAIN:  if (!r_iss_v && !r_p1_v) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue = 1'b0;
    w_row   = '0;
    w_col   = '0;
    w_src   = r_ptr;
    if (w_accept && w_legal) begin
      w_issue = 1'b1;
      w_src   = i_base_addr;
    end else if ((r_state == S_STREAM) && !w_last) begin
      w_issue = 1'b1;
      if (r_col == r_sl_m1) begin
        w_row = r_row + CW'(1);
        w_col = '0;
      end else begin
        w_row = r_row;
        w_col = r_col + CW'(1);
      end
    end
  end

  // Memory-backed pixels are contiguous in raster order, so a running pointer replaces row*img_w.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_sl_m1    <= '0;
      r_sh_m1    <= '0;
      r_ptr      <= '0;
      r_mem_ren  <= 1'b0;
      r_mem_addr <= '0;
      r_iss_v    <= 1'b0;
      r_iss_win  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sl_m1 <= w_sl_m1_in;
        r_sh_m1 <= w_sh_m1_in;
      end
      if (w_issue) begin
        r_row      <= w_row;
        r_col      <= w_col;
        r_mem_ren  <= w_pos_mem;
        r_mem_addr <= w_pos_mem ? w_src : '0;
        r_ptr      <= w_pos_mem ? w_src + ADDR_W'(1) : w_src;
      end else begin
        r_mem_ren  <= 1'b0;
        r_mem_addr <= '0;
      end
      r_iss_v   <= w_issue;
      r_iss_win <= w_issue && w_pos_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_v         <= 1'b0;
      r_p1_mem       <= 1'b0;
      r_p1_win       <= 1'b0;
      r_p2_win       <= 1'b0;
      r_stream_valid <= 1'b0;
      r_stream_data  <= 16'h0000;
      r_win_valid    <= 1'b0;
    end else begin
      r_p1_v         <= r_iss_v;
      r_p1_mem       <= r_mem_ren;
      r_p1_win       <= r_iss_win;
      r_stream_valid <= r_p1_v;
      r_stream_data  <= (r_p1_v && r_p1_mem) ? i_mem_rdata : 16'h0000;
      r_p2_win       <= r_p1_v && r_p1_win;
      r_win_valid    <= r_p2_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_accept)                r_busy <= 1'b1;
      else if (r_state == S_DONE)  r_busy <= 1'b0;
      else                         r_busy <= r_busy;
      r_done <= (r_state == S_DONE);
    end
  end

  assign o_mem_ren      = r_mem_ren;
  assign o_mem_addr     = r_mem_addr;
  assign o_stream_data  = r_stream_data;
  assign o_stream_valid = r_stream_valid;
  assign o_win_valid    = r_win_valid;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_ifmap_streamer.sv
// Scoreboard bench for ifmap_streamer: a raster reference model queues expected addresses, pixels and window flags.
module tb_ifmap_streamer;
  localparam int ADDR_W = 12;
  localparam int DIM_W  = 8;
`ifdef IFMAP_STREAMER_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  img_w = '0, img_h = '0;
  logic [ADDR_W-1:0] base = '0;
  logic              mem_ren, stream_valid, win_valid, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata = 16'h0000;
  logic [15:0]       stream_data;
  logic [15:0]       mem [0:4095];

  ifmap_streamer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_img_w(img_w), .i_img_h(img_h),
    .i_base_addr(base), .o_mem_ren(mem_ren), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
    .o_stream_data(stream_data), .o_stream_valid(stream_valid), .o_win_valid(win_valid),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0, n_err = 0;
  int n_done = 0, n_win = 0, pix_cnt = 0, last_win_cyc = -100;
  logic [15:0]       exp_data[$];
  bit                exp_mem[$];
  bit                exp_win[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int                ren_cyc[$];
  bit                prev_win = 1'b0;

  // SRAM model: one-cycle read latency, garbage on the bus when not reading.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= mem_ren ? mem[mem_addr] : 16'($urandom);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_win = 1'b0;
    end else begin
      chk("win_valid", int'(win_valid), int'(prev_win));
      if (win_valid) begin
        n_win++;
        last_win_cyc = cyc;
      end
      if (mem_ren) begin
        if (exp_addr.size() == 0) chk("unexpected_mem_ren", 1, 0);
        else chk("mem_addr", int'(mem_addr), int'(exp_addr.pop_front()));
        ren_cyc.push_back(cyc);
      end
      if (stream_valid) begin
        pix_cnt++;
        if (exp_data.size() == 0) begin
          chk("unexpected_stream_valid", 1, 0);
          prev_win = 1'b0;
        end else begin
          chk("stream_data", int'(stream_data), int'(exp_data.pop_front()));
          prev_win = exp_win.pop_front();
          if (exp_mem.pop_front()) begin
            if (ren_cyc.size() == 0) chk("ren_to_pixel_missing", 1, 0);
            else chk("ren_to_pixel_latency", cyc - ren_cyc.pop_front(), 2);
          end
        end
      end else begin
        chk("idle_data_zero", int'(stream_data), 0);
        prev_win = 1'b0;
      end
      if (done) begin
        n_done++;
        chk("busy_in_done", int'(busy), 0);
      end
    end
  end

  // Reference: positions in raster order over the (optionally padded) stream grid.
  task automatic model_frame(input int w, input int h, input int b, output bit legal, output int wins);
    int sl, sh, a;
    bit border;
    sl = w + 2 * PAD;
    sh = h + 2 * PAD;
    legal = (PAD == 1) ? (w >= 1 && h >= 1) : (w >= 3 && h >= 3);
    wins = legal ? (sl - 2) * (sh - 2) : 0;
    if (legal) begin
      for (int r = 0; r < sh; r++) begin
        for (int c = 0; c < sl; c++) begin
          border = (PAD == 1) && (r == 0 || c == 0 || r == sh - 1 || c == sl - 1);
          if (border) begin
            exp_data.push_back(16'h0000);
            exp_mem.push_back(1'b0);
          end else begin
            a = (b + (r - PAD) * w + (c - PAD)) % 4096;
            exp_addr.push_back(ADDR_W'(a));
            exp_data.push_back(mem[a]);
            exp_mem.push_back(1'b1);
          end
          exp_win.push_back(r >= 2 && c >= 2);
        end
      end
    end
  endtask

  task automatic issue_start(input int w, input int h, input int b, output bit legal, output int wins);
    @(negedge clk);
    img_w = DIM_W'(w);
    img_h = DIM_W'(h);
    base  = ADDR_W'(b);
    start = 1'b1;
    model_frame(w, h, b, legal, wins);
  endtask

  task automatic run_frame(input int w, input int h, input int b, input bit restart);
    bit legal, got;
    int wins, t0, nd0, nw0;
    nd0 = n_done;
    nw0 = n_win;
    issue_start(w, h, b, legal, wins);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = restart && (i == 4);
      if (start) begin
        img_w = DIM_W'($urandom_range(3, 9));
        img_h = DIM_W'($urandom_range(3, 9));
        base  = ADDR_W'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else if (legal) begin
      chk("done_after_last_win", cyc - last_win_cyc, 1);
    end else begin
      chk("illegal_done_latency", cyc - t0, 2);
    end
    chk("pixels_left", exp_data.size(), 0);
    chk("addrs_left", exp_addr.size(), 0);
    repeat (3) @(negedge clk);
    chk("done_pulses", n_done - nd0, 1);
    chk("window_count", n_win - nw0, wins);
  endtask

  task automatic run_abort(input int w, input int h, input int b);
    bit legal, hit;
    int wins, pc0;
    pc0 = pix_cnt;
    issue_start(w, h, b, legal, wins);
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (pix_cnt - pc0 >= 7) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_reached_pixel7", int'(hit), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_ren", int'(mem_ren), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_stream_data", int'(stream_data), 0);
    chk("rst_stream_valid", int'(stream_valid), 0);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    exp_data.delete();
    exp_mem.delete();
    exp_win.delete();
    exp_addr.delete();
    ren_cyc.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset_busy", int'(busy), 0);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'(a);
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_mem_ren", int'(mem_ren), 0);
    chk("reset_stream_valid", int'(stream_valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(4, 4, 12'h010, 1'b0);
    run_frame(2, 5, 12'h020, 1'b0);
    run_frame(4, 4, 12'h010, 1'b1);
    run_abort(4, 4, 12'h010);
    run_frame(4, 4, 12'h010, 1'b0);
    run_frame(3, 3, 12'h100, 1'b0);
    run_frame(3, 3, 12'hFFE, 1'b0);
    run_frame(0, 3, 12'h000, 1'b0);
    for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
    for (int k = 0; k < 20; k++) begin
      run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)), k[0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifmap_streamer.md
IFMAP_STREAMER -- requirements
Module: ifmap_streamer

Interface
REQ-001 Parameter ADDR_W, default 12: SRAM word-address width.
REQ-002 Parameter DIM_W, default 8: width of image dimension fields.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to stream one feature map; sampled only in IDLE.
REQ-006 img_w  input  DIM_W  map width in pixels; sampled on accepted start.
REQ-007 img_h  input  DIM_W  map height in pixels; sampled on accepted start.
REQ-008 base_addr  input  ADDR_W  address of pixel (0,0); raster order, row stride = img_w; sampled on accepted start.
REQ-009 mem_ren  output  1  SRAM read enable.
REQ-010 mem_addr  output  ADDR_W  SRAM read address.
REQ-011 mem_rdata  input  16  SRAM read data, valid exactly one cycle after mem_ren.
REQ-012 stream_data  output  16  pixel stream into the downstream 3x3 line buffer (LEN = stream row length).
REQ-013 stream_valid  output  1  stream_data holds a pixel this cycle.
REQ-014 win_valid  output  1  downstream 3x3 window registers hold a complete window this cycle.
REQ-015 busy  output  1  high from accepted start until done.
REQ-016 done  output  1  one-cycle pulse when the last pixel and its window flag have been emitted.

Function
REQ-017 FSM states SHALL be IDLE, STREAM, DRAIN, DONE.
REQ-018 IDLE -> STREAM on start when dimensions are legal; IDLE -> DONE on start when illegal; start in any other state SHALL be ignored.
REQ-019 Legal: img_w >= 3 and img_h >= 3 (padding off); img_w >= 1 and img_h >= 1 (padding on).
REQ-020 STREAM: one stream position per cycle, no gaps, raster order, column counter wrapping to 0 with row increment at end of row.
REQ-021 Memory-backed positions: mem_ren=1, mem_addr = base_addr + row*img_w + col, modulo 2^ADDR_W.
REQ-022 STREAM -> DRAIN in the cycle after the last position is issued; DRAIN lasts until the pipeline is empty, then -> DONE.
REQ-023 stream_data/stream_valid SHALL be registered from mem_rdata, appearing 2 cycles after the corresponding mem_ren.
REQ-024 Stream row length SL and height SH: SL=img_w, SH=img_h (padding off).
REQ-025 win_valid SHALL be high exactly one cycle after stream_valid for a stream position (r,c) with r >= 2 and c >= 2; otherwise low.
REQ-026 Window count per map SHALL be (SL-2)*(SH-2).
REQ-027 DONE: done=1 for one cycle, busy=0 in that cycle, then -> IDLE; start accepted on the following cycle.
REQ-028 When not stream_valid, stream_data SHALL be 0.
REQ-029 Illegal-dimension start: no mem_ren, no stream_valid, busy high 1 cycle, done pulse on the next cycle.

Reset
REQ-030 rst_n low SHALL immediately force FSM to IDLE and mem_ren, mem_addr, stream_data, stream_valid, win_valid, busy, done to 0, including mid-frame; pending reads SHALL be discarded.
REQ-031 After rst_n rises, the first frame SHALL begin only on a new start.

Configuration
REQ-032 Macro IFMAP_STREAMER_PAD_EN SHALL enable one-pixel zero padding.
REQ-033 With the macro defined: SL=img_w+2, SH=img_h+2; border positions emit 0 with mem_ren=0 and identical 2-cycle timing; interior (r,c) reads base_addr+(r-1)*img_w+(c-1); window count = img_w*img_h.
REQ-034 Without the macro: no padding logic; behaviour per REQ-019..REQ-026 unpadded.

Verification
REQ-035 Reset, start with img_w=4,img_h=4,base=0x010, memory[a]=a -> 16 stream_valid cycles, data 0x010..0x01F contiguous, 4 win_valid pulses, done 1 cycle after last win_valid.
REQ-036 start with img_w=2,img_h=5 (no pad) -> no mem_ren, no stream_valid, done pulse 2 cycles after start.
REQ-037 start re-asserted during STREAM -> ignored; frame output identical to REQ-035; exactly one done.
REQ-038 rst_n low at 7th stream pixel -> all outputs 0 within same cycle; next start streams full frame from base_addr.
REQ-039 PAD_EN, img_w=3,img_h=3,base=0x100 -> 25 stream pixels, row0/row4/col0/col4 zero with mem_ren=0, 9 win_valid pulses.
REQ-040 base_addr=0xFFE, img_w=3,img_h=3 -> addresses wrap: 0xFFE,0xFFF,0x000,... ; 1 win_valid.
